uart_rx_packer: RTL and testbench

UART receiver and byte packer that sits between the board `uart_rx` pin and the write-side FIFO of the DDR3 test datapath inside `ddr3_test_top`. It recovers 8N1 frames at a runtime-selectable baud rate and assembles `DATA_IN_WIDTH/8` consecutive bytes, least-significant byte first, into one word. Each word is presented on a valid/ready interface to the FIFO write port.

---
 rtl/uart_pkg.sv | 47 ++++
 rtl/uart_rx_packer_if.sv | 11 +
 rtl/uart_byte_rx.sv | 121 ++++++++++++
 rtl/uart_rx_packer.sv | 97 +++++++++
 tb/tb_uart_rx_packer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud-select codes, divisor arithmetic and receiver
// state encoding. Also used by uart_tx.
package uart_pkg;

    localparam logic [2:0] BAUD_9600   = 3'd0;
    localparam logic [2:0] BAUD_19200  = 3'd1;
    localparam logic [2:0] BAUD_38400  = 3'd2;
    localparam logic [2:0] BAUD_57600  = 3'd3;
    localparam logic [2:0] BAUD_115200 = 3'd4;
    localparam logic [2:0] BAUD_230400 = 3'd5;
    localparam logic [2:0] BAUD_460800 = 3'd6;
    localparam logic [2:0] BAUD_921600 = 3'd7;

    localparam int DEFAULT_CLK_FREQ = 50_000_000;

    function automatic int baud_rate(input int sel);
        case (sel)
            0:       return 9600;
            1:       return 19200;
            2:       return 38400;
            3:       return 57600;
            4:       return 115200;
            5:       return 230400;
            6:       return 460800;
            default: return 921600;
        endcase
    endfunction

    // Rounded clocks-per-bit for a given clock frequency and baud select.
    function automatic int baud_div(input int clk_freq, input int sel);
        int rate;
        rate = baud_rate(sel);
        return (clk_freq + rate / 2) / rate;
    endfunction

    // The slowest rate sets the counter width.
    localparam int BAUD_CNT_W = $clog2(baud_div(DEFAULT_CLK_FREQ, 0));

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/uart_rx_packer_if.sv
// Word output stream of the UART packer toward the FIFO write port.
interface uart_rx_packer_if #(
    parameter int DATA_IN_WIDTH = 16
) ();
    logic [DATA_IN_WIDTH-1:0] dout;
    logic                     dout_valid;
    logic                     dout_ready;

    modport master (output dout, output dout_valid, input dout_ready);
    modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: input synchroniser, baud counter and framing FSM.
// All outputs are registered; byte_done/frame_err are one-cycle pulses.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] baud_sel,
    input  logic       uart_rx,
    output logic [7:0] rx_byte,
    output logic       byte_done,
    output logic       frame_err,
    output logic       rx_busy
);
    localparam int CNT_W = $clog2(baud_div(CLK_FREQ, int'(BAUD_9600)));

    logic [1:0]       sync_reg;
    logic             line_prev_reg;
    logic             line;
    logic             fall;
    logic [CNT_W-1:0] div_table [8];
    logic [CNT_W-1:0] div_reg;
    logic [CNT_W-1:0] half_m1;
    logic [CNT_W-1:0] div_m1;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       bit_idx_reg;
    rx_state_t        state_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi = gi + 1) begin : g_div
            assign div_table[gi] = CNT_W'(baud_div(CLK_FREQ, gi));
        end
    endgenerate

    assign line    = sync_reg[1];
    assign fall    = line_prev_reg & ~line;
    assign half_m1 = (div_reg >> 1) - CNT_W'(1);
    assign div_m1  = div_reg - CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg      <= 2'b11;
            line_prev_reg <= 1'b1;
            state_reg     <= RX_IDLE;
            cnt_reg       <= '0;
            bit_idx_reg   <= '0;
            div_reg       <= CNT_W'(baud_div(CLK_FREQ, 0));
            rx_byte       <= '0;
            byte_done     <= 1'b0;
            frame_err     <= 1'b0;
            rx_busy       <= 1'b0;
        end else begin
            sync_reg      <= {sync_reg[0], uart_rx};
            line_prev_reg <= line;
            byte_done     <= 1'b0;
            frame_err     <= 1'b0;

            case (state_reg)
                RX_IDLE: begin
                    // Baud rate is frozen for the whole frame from here on.
                    if (fall) begin
                        div_reg     <= div_table[baud_sel];
                        cnt_reg     <= '0;
                        bit_idx_reg <= '0;
                        rx_busy     <= 1'b1;
                        state_reg   <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt_reg == half_m1) begin
                        cnt_reg <= '0;
                        if (line) begin
                            rx_busy   <= 1'b0;
                            state_reg <= RX_IDLE;
                        end else begin
                            state_reg <= RX_DATA;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt_reg == div_m1) begin
                        cnt_reg     <= '0;
                        rx_byte     <= {line, rx_byte[7:1]};
                        bit_idx_reg <= bit_idx_reg + 3'd1;
                        if (bit_idx_reg == 3'd7)
                            state_reg <= RX_STOP;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt_reg == div_m1) begin
                        cnt_reg <= '0;
                        rx_busy <= 1'b0;
                        if (line) begin
                            byte_done <= 1'b1;
                            state_reg <= RX_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state_reg <= RX_WAIT_HIGH;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                RX_WAIT_HIGH: begin
                    // A held-low line (break) must not be taken as a new start bit.
                    if (line)
                        state_reg <= RX_IDLE;
                end
                default: state_reg <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_packer.sv
// UART receiver plus byte packer: assembles DATA_IN_WIDTH/8 bytes, LSB first,
// into a word held in a one-deep output register with valid/ready handshake.
module uart_rx_packer
    import uart_pkg::*;
#(
    parameter int CLK_FREQ      = 50_000_000,
    parameter int DATA_IN_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       baud_sel,
    input  logic             uart_rx,
    uart_rx_packer_if.master out_if,
    output logic             frame_err,
    output logic             ovf_err,
    output logic             rx_busy
);
    localparam int NB    = DATA_IN_WIDTH / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    logic [7:0]               rx_byte;
    logic                     byte_done;
    logic                     frame_err_int;
    logic [IDX_W-1:0]         byte_idx_reg;
    logic [DATA_IN_WIDTH-1:0] assy_reg;
    logic [DATA_IN_WIDTH-1:0] word_next;
    logic [DATA_IN_WIDTH-1:0] dout_reg;
    logic                     dout_valid_reg;
    logic                     ovf_reg;
    logic                     last_byte;
    logic                     word_done;
    logic                     accept;
    logic                     load_word;

    uart_byte_rx #(
        .CLK_FREQ (CLK_FREQ)
    ) u_byte_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .baud_sel  (baud_sel),
        .uart_rx   (uart_rx),
        .rx_byte   (rx_byte),
        .byte_done (byte_done),
        .frame_err (frame_err_int),
        .rx_busy   (rx_busy)
    );

    // The incoming byte overlays its lane; word_next is the complete word on the last byte.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi = gi + 1) begin : g_lane
            assign word_next[8*gi +: 8] = (byte_idx_reg == IDX_W'(gi)) ? rx_byte
                                                                       : assy_reg[8*gi +: 8];
        end
    endgenerate

    assign last_byte = (byte_idx_reg == IDX_W'(NB - 1));
    assign word_done = byte_done & last_byte;
    assign accept    = dout_valid_reg & out_if.dout_ready;
    assign load_word = word_done & (~dout_valid_reg | out_if.dout_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx_reg   <= '0;
            assy_reg       <= '0;
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
            ovf_reg        <= 1'b0;
        end else begin
            ovf_reg <= 1'b0;

            if (frame_err_int) begin
                byte_idx_reg <= '0;
            end else if (byte_done) begin
                assy_reg     <= word_next;
                byte_idx_reg <= last_byte ? '0 : byte_idx_reg + IDX_W'(1);
            end

            // A word completing while the output is stalled is dropped, not queued.
            if (load_word) begin
                dout_reg       <= word_next;
                dout_valid_reg <= 1'b1;
            end else begin
                if (word_done)
                    ovf_reg <= 1'b1;
                if (accept)
                    dout_valid_reg <= 1'b0;
            end
        end
    end

    assign out_if.dout       = dout_reg;
    assign out_if.dout_valid = dout_valid_reg;
    assign frame_err         = frame_err_int;
    assign ovf_err           = ovf_reg;

endmodule

// File: tb/tb_uart_rx_packer.sv
// Self-checking bench for uart_rx_packer: serial frames in, words scoreboarded out.
module tb_uart_rx_packer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] baud_sel;
    logic       uart_rx;
    logic       dout_ready;
    logic       frame_err;
    logic       ovf_err;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_start = 0;
    int rise_cyc = 0;
    int valid_cycles = 0;
    int ferr_cnt = 0;
    int ovf_cnt = 0;
    logic prev_valid = 1'b0;
    logic [15:0] exp_q [$];
    logic [15:0] exp_w;

    uart_rx_packer_if #(.DATA_IN_WIDTH(16)) out_if ();
    assign out_if.dout_ready = dout_ready;

    uart_rx_packer #(
        .CLK_FREQ      (50_000_000),
        .DATA_IN_WIDTH (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .baud_sel  (baud_sel),
        .uart_rx   (uart_rx),
        .out_if    (out_if),
        .frame_err (frame_err),
        .ovf_err   (ovf_err),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Line is left at the stop-bit level on return.
    task automatic send_byte(input logic [7:0] b, input logic stop, input int div,
                             input int chg_bit, input logic [2:0] chg_sel);
        @(posedge clk);
        #1;
        last_start = cyc;
        uart_rx = 1'b0;
        wait_clks(div);
        for (int i = 0; i < 8; i++) begin
            if (i == chg_bit) baud_sel = chg_sel;
            uart_rx = b[i];
            wait_clks(div);
        end
        uart_rx = stop;
        wait_clks(div);
    endtask

    // Output monitor / scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) ferr_cnt++;
            if (ovf_err) ovf_cnt++;
            if (out_if.dout_valid) valid_cycles++;
            if (out_if.dout_valid && !prev_valid) rise_cyc = cyc;
            if (out_if.dout_valid && dout_ready) begin
                check_val("word_avail", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_w = exp_q.pop_front();
                    $display("word accepted dout=%h expected=%h", out_if.dout, exp_w);
                    check_val("word", 32'(out_if.dout), 32'(exp_w));
                end
            end
        end
        prev_valid = out_if.dout_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int v0, f0, o0;
        rst_n = 1'b0;
        uart_rx = 1'b1;
        baud_sel = 3'd5;
        dout_ready = 1'b1;
        wait_clks(3);
        check_val("rst_dout", 32'(out_if.dout), 32'd0);
        check_val("rst_valid", 32'(out_if.dout_valid), 32'd0);
        check_val("rst_ferr", 32'(frame_err), 32'd0);
        check_val("rst_ovf", 32'(ovf_err), 32'd0);
        check_val("rst_busy", 32'(rx_busy), 32'd0);
        rst_n = 1'b1;
        wait_clks(5);

        // Two bytes at 230400 form one word; valid rises one clock after the stop sample.
        v0 = valid_cycles; f0 = ferr_cnt; o0 = ovf_cnt;
        exp_q.push_back(16'h1234);
        send_byte(8'h34, 1'b1, 217, -1, 3'd0);
        send_byte(8'h12, 1'b1, 217, -1, 3'd0);
        check_val("t1_rise_cyc", 32'(rise_cyc), 32'(last_start + 4 + 108 + 9 * 217));
        wait_clks(20);
        check_val("t1_valid_cycles", 32'(valid_cycles - v0), 32'd1);
        check_val("t1_ferr", 32'(ferr_cnt - f0), 32'd0);
        check_val("t1_ovf", 32'(ovf_cnt - o0), 32'd0);
        check_val("t1_drain", 32'(exp_q.size()), 32'd0);

        // Start-bit glitch at 115200.
        baud_sel = 3'd4;
        v0 = valid_cycles; f0 = ferr_cnt;
        @(posedge clk);
        #1;
        uart_rx = 1'b0;
        wait_clks(100);
        uart_rx = 1'b1;
        wait_clks(119);
        check_val("t2_busy_before", 32'(rx_busy), 32'd1);
        wait_clks(1);
        check_val("t2_busy_after", 32'(rx_busy), 32'd0);
        wait_clks(500);
        check_val("t2_no_word", 32'(valid_cycles - v0), 32'd0);
        check_val("t2_no_ferr", 32'(ferr_cnt - f0), 32'd0);
        exp_q.push_back(16'hAA55);
        send_byte(8'h55, 1'b1, 434, -1, 3'd0);
        send_byte(8'hAA, 1'b1, 434, -1, 3'd0);
        wait_clks(20);
        check_val("t2_drain", 32'(exp_q.size()), 32'd0);

        // Frame error discards the partial word; a held break is not a start.
        baud_sel = 3'd7;
        v0 = valid_cycles; f0 = ferr_cnt;
        send_byte(8'h77, 1'b1, 54, -1, 3'd0);
        send_byte(8'hA5, 1'b0, 54, -1, 3'd0);
        wait_clks(3000);
        check_val("t3_busy_break", 32'(rx_busy), 32'd0);
        check_val("t3_ferr_one", 32'(ferr_cnt - f0), 32'd1);
        check_val("t3_no_word", 32'(valid_cycles - v0), 32'd0);
        uart_rx = 1'b1;
        wait_clks(100);
        exp_q.push_back(16'h0201);
        send_byte(8'h01, 1'b1, 54, -1, 3'd0);
        send_byte(8'h02, 1'b1, 54, -1, 3'd0);
        wait_clks(20);
        check_val("t3_drain", 32'(exp_q.size()), 32'd0);
        check_val("t3_ferr_total", 32'(ferr_cnt - f0), 32'd1);

        // Stalled output drops the second word; later a same-cycle accept and load.
        o0 = ovf_cnt;
        dout_ready = 1'b0;
        exp_q.push_back(16'h0201);
        send_byte(8'h01, 1'b1, 54, -1, 3'd0);
        send_byte(8'h02, 1'b1, 54, -1, 3'd0);
        send_byte(8'h03, 1'b1, 54, -1, 3'd0);
        send_byte(8'h04, 1'b1, 54, -1, 3'd0);
        wait_clks(10);
        check_val("t4_held_dout", 32'(out_if.dout), 32'h0201);
        check_val("t4_held_valid", 32'(out_if.dout_valid), 32'd1);
        check_val("t4_ovf_one", 32'(ovf_cnt - o0), 32'd1);
        dout_ready = 1'b1;
        wait_clks(3);
        check_val("t4_valid_fall", 32'(out_if.dout_valid), 32'd0);
        check_val("t4_drain1", 32'(exp_q.size()), 32'd0);
        dout_ready = 1'b0;
        o0 = ovf_cnt;
        exp_q.push_back(16'h0605);
        exp_q.push_back(16'h0807);
        send_byte(8'h05, 1'b1, 54, -1, 3'd0);
        send_byte(8'h06, 1'b1, 54, -1, 3'd0);
        send_byte(8'h07, 1'b1, 54, -1, 3'd0);
        fork
            send_byte(8'h08, 1'b1, 54, -1, 3'd0);
            begin
                @(posedge clk);
                #1;
                wait_clks(3 + 27 + 9 * 54);
                dout_ready = 1'b1;
            end
        join
        wait_clks(10);
        check_val("t4_same_cycle_ovf", 32'(ovf_cnt - o0), 32'd0);
        check_val("t4_drain2", 32'(exp_q.size()), 32'd0);
        check_val("t4_valid_end", 32'(out_if.dout_valid), 32'd0);

        // Reset during the second byte of a word.
        send_byte(8'h11, 1'b1, 54, -1, 3'd0);
        @(posedge clk);
        #1;
        uart_rx = 1'b0;
        wait_clks(54);
        uart_rx = 1'b0;
        wait_clks(54);
        uart_rx = 1'b1;
        wait_clks(10);
        check_val("t6_busy_mid", 32'(rx_busy), 32'd1);
        rst_n = 1'b0;
        uart_rx = 1'b1;
        wait_clks(2);
        check_val("t6_rst_dout", 32'(out_if.dout), 32'd0);
        check_val("t6_rst_valid", 32'(out_if.dout_valid), 32'd0);
        check_val("t6_rst_busy", 32'(rx_busy), 32'd0);
        check_val("t6_rst_errs", 32'({frame_err, ovf_err}), 32'd0);
        rst_n = 1'b1;
        wait_clks(10);
        exp_q.push_back(16'h4433);
        send_byte(8'h33, 1'b1, 54, -1, 3'd0);
        send_byte(8'h44, 1'b1, 54, -1, 3'd0);
        wait_clks(20);
        check_val("t6_drain", 32'(exp_q.size()), 32'd0);

        // Baud change mid-frame applies only to the next frame.
        baud_sel = 3'd5;
        exp_q.push_back(16'hC35A);
        send_byte(8'h5A, 1'b1, 217, 3, 3'd0);
        send_byte(8'hC3, 1'b1, 5208, -1, 3'd0);
        check_val("t5_rise_cyc", 32'(rise_cyc), 32'(last_start + 4 + 2604 + 9 * 5208));
        wait_clks(20);
        check_val("t5_drain", 32'(exp_q.size()), 32'd0);

        wait_clks(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
